// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam bit ZERO_REG_DEF = 1'b1;

    // Number of bits needed to address num_regs architectural registers.
    function automatic int addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Decode/issue and writeback bus of the register file: two write ports,
// NUM_RD read ports and the issue-check handshake.
interface regfile_mp_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
);

    localparam int ADDR_W = addr_w(NUM_REGS);

    logic [1:0]               wr_en;
    logic [2*ADDR_W-1:0]      wr_addr;
    logic [2*DATA_W-1:0]      wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     iss_valid;
    logic                     iss_dst_en;
    logic [ADDR_W-1:0]        iss_dst;
    logic [NUM_RD-1:0]        iss_src_en;
    logic                     iss_stall;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        output iss_valid, iss_dst_en, iss_dst, iss_src_en,
        input  rd_data, iss_stall, busy_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        input  iss_valid, iss_dst_en, iss_dst, iss_src_en,
        output rd_data, iss_stall, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: marks destinations of issued instructions as
// pending, clears them on writeback and stalls issue on RAW/WAW hazards.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF,
    localparam int ADDR_W  = addr_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iss_valid,
    input  logic                     iss_dst_en,
    input  logic [ADDR_W-1:0]        iss_dst,
    input  logic [NUM_RD-1:0]        iss_src_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    output logic                     iss_stall,
    output logic [ADDR_W:0]          busy_cnt
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     busy_cnt_q, busy_cnt_d;
    logic                src_stall;

    // True when either write port retires a result to register a this cycle.
    function automatic logic wb_hit(input logic [ADDR_W-1:0] a,
                                    input logic [1:0] en,
                                    input logic [2*ADDR_W-1:0] addrs);
        return (en[0] && addrs[0 +: ADDR_W] == a) ||
               (en[1] && addrs[ADDR_W +: ADDR_W] == a);
    endfunction

    // Source RAW stalls only when the pending value is not being bypassed this cycle.
    always_comb begin
        src_stall = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (iss_src_en[i] && busy_q[rd_addr[i*ADDR_W +: ADDR_W]] &&
                !wb_hit(rd_addr[i*ADDR_W +: ADDR_W], wr_en, wr_addr)) begin
                src_stall = 1'b1;
            end
        end
        iss_stall = iss_valid && (src_stall || (iss_dst_en && busy_q[iss_dst]));
    end

    // Writebacks clear busy bits first so a newly accepted writer of the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < 2; p++) begin
            if (wr_en[p]) begin
                busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_valid && !iss_stall && iss_dst_en) begin
            busy_d[iss_dst] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Population count of the next busy vector, so the registered count tracks the flops.
    always_comb begin
        busy_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
        end
    end

    // Busy state; reset drops every pending writer along with the pipeline flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// MIPS pipeline register file: NUM_RD bypassed read ports, two write ports
// and the issue scoreboard that holds instructions on RAW/WAW hazards.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter bit ZERO_REG = ZERO_REG_DEF,
    localparam int ADDR_W  = addr_w(NUM_REGS)
) (
    input logic                    clk,
    input logic                    reset,
    regfile_mp_scoreboard_if.slave bus
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // Apply port 0 then port 1 so that port 1 wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < 2; p++) begin
            if (bus.wr_en[p] && !(ZERO_REG && bus.wr_addr[p*ADDR_W +: ADDR_W] == '0)) begin
                regs_d[bus.wr_addr[p*ADDR_W +: ADDR_W]] = bus.wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    // Register storage, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] val;

        assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

        // Zero-register, then same-cycle writeback bypass (port 1 first), then storage.
        always_comb begin
            if (ZERO_REG && addr == '0) begin
                val = '0;
            end else if (bus.wr_en[1] && bus.wr_addr[ADDR_W +: ADDR_W] == addr) begin
                val = bus.wr_data[DATA_W +: DATA_W];
            end else if (bus.wr_en[0] && bus.wr_addr[0 +: ADDR_W] == addr) begin
                val = bus.wr_data[0 +: DATA_W];
            end else begin
                val = regs_q[addr];
            end
        end

        assign bus.rd_data[i*DATA_W +: DATA_W] = val;
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .iss_valid  (bus.iss_valid),
        .iss_dst_en (bus.iss_dst_en),
        .iss_dst    (bus.iss_dst),
        .iss_src_en (bus.iss_src_en),
        .rd_addr    (bus.rd_addr),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .iss_stall  (bus.iss_stall),
        .busy_cnt   (bus.busy_cnt)
    );

endmodule
